// File: rtl/phase_pkg.sv
// Shared types and defaults for the multi-channel DDS phase-offset controller.
package phase_pkg;

   // Step FSM: wait for a press, make the first step, wait out the
   // auto-repeat delay, then step at the repeat rate until release.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STEP   = 2'd1,
      HOLD   = 2'd2,
      REPEAT = 2'd3
   } phase_state_t;

   // 1 degree and 90 degrees of a 32-bit phase word.
   localparam longint unsigned FINE_STEP_DEFAULT   = 64'd11930465;
   localparam longint unsigned COARSE_STEP_DEFAULT = 64'd1073741824;

   // Channel selects that do not address a real channel fall back to channel 0.
   function automatic int unsigned ch_index(input int unsigned sel,
                                            input int unsigned channels);
      return (sel < channels) ? sel : 32'd0;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability debouncer for one active-low button.
// deb_n follows the synchronised level only after it has differed from the
// current deb_n for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_n,
   output logic deb_n
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Bring the asynchronous button into the clk domain; resets to "released".
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= raw_n;
         sync2 <= sync1;
      end
   end

   // Count consecutive cycles of disagreement; accept the new level on the last one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb_n <= 1'b1;
         cnt   <= '0;
      end else if (sync2 == deb_n) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         deb_n <= sync2;
         cnt   <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/phase_offset_ctrl.sv
// Push-button phase-offset controller for CHANNELS DDS channels.
// Debounced add/sub buttons step the selected channel's offset by a fine or
// coarse amount, with auto-repeat while held; clear zeroes one channel.
module phase_offset_ctrl
   import phase_pkg::*;
#(
   parameter int unsigned     PHASE_W         = 32,
   parameter int unsigned     CHANNELS        = 2,
   parameter longint unsigned FINE_STEP       = FINE_STEP_DEFAULT,
   parameter longint unsigned COARSE_STEP     = COARSE_STEP_DEFAULT,
   parameter int unsigned     DEBOUNCE_CYCLES = 500000,
   parameter int unsigned     REPEAT_DELAY    = 25000000,
   parameter int unsigned     REPEAT_RATE     = 5000000,
   localparam int unsigned    SEL_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        add_n,
   input  logic                        sub_n,
   input  logic [SEL_W-1:0]            sel,
   input  logic                        coarse,
   input  logic                        clear,
   output logic [CHANNELS*PHASE_W-1:0] phase_out,
   output logic                        step_pulse,
   output logic [1:0]                  state_dbg
);

   localparam logic [PHASE_W-1:0] FINE_V   = PHASE_W'(FINE_STEP);
   localparam logic [PHASE_W-1:0] COARSE_V = PHASE_W'(COARSE_STEP);

   localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

   logic               add_deb_n;
   logic               sub_deb_n;
   logic               add_p;
   logic               sub_p;
   logic               leave;
   logic               step_fire;
   logic [SEL_W-1:0]   clr_ch;

   phase_state_t       state;
   logic               dir_sub;
   logic [SEL_W-1:0]   ch;
   logic [PHASE_W-1:0] step_val;
   logic [CNT_W-1:0]   cnt;
   logic [PHASE_W-1:0] offset [CHANNELS];

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add_deb (
      .clk   (clk),
      .reset (reset),
      .raw_n (add_n),
      .deb_n (add_deb_n)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sub_deb (
      .clk   (clk),
      .reset (reset),
      .raw_n (sub_n),
      .deb_n (sub_deb_n)
   );

   assign add_p = !add_deb_n;
   assign sub_p = !sub_deb_n;

   // An active hold ends when its own button releases or the other one joins it.
   assign leave = dir_sub ? (!sub_p || add_p) : (!add_p || sub_p);

   // The first step is unconditional; repeat steps only while the hold survives.
   assign step_fire = (state == STEP) ||
                      ((state == REPEAT) && !leave && (cnt == '0));

   assign clr_ch    = SEL_W'(ch_index(32'(sel), CHANNELS));
   assign state_dbg = state;

   // Step sequencing: latch the request on press, then time delay and repeats.
   // HOLD hands over to REPEAT with the counter already at zero, so the first
   // repeat lands one cycle after the delay expires and the rest follow at the rate.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         dir_sub  <= 1'b0;
         ch       <= '0;
         step_val <= '0;
         cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (add_p ^ sub_p) begin
                  state    <= STEP;
                  dir_sub  <= sub_p;
                  ch       <= SEL_W'(ch_index(32'(sel), CHANNELS));
                  step_val <= coarse ? COARSE_V : FINE_V;
               end
            end
            STEP: begin
               state <= HOLD;
               cnt   <= DELAY_LOAD;
            end
            HOLD: begin
               if (leave) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  state <= REPEAT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            REPEAT: begin
               if (leave) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  cnt <= RATE_LOAD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Offset registers: wrap-around step, then clear overrides on its channel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < CHANNELS; k++) begin
            offset[k] <= '0;
         end
         step_pulse <= 1'b0;
      end else begin
         if (step_fire) begin
            offset[ch] <= dir_sub ? (offset[ch] - step_val) : (offset[ch] + step_val);
         end
         if (clear) begin
            offset[clr_ch] <= '0;
         end
         step_pulse <= step_fire || clear;
      end
   end

   // Pack the channel offsets onto the output bus.
   always_comb begin
      phase_out = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         phase_out[k*PHASE_W +: PHASE_W] = offset[k];
      end
   end

endmodule

// File: tb/tb_phase_offset_ctrl.sv
// Bench for phase_offset_ctrl with small timing parameters.
module tb_phase_offset_ctrl;

   localparam int CH = 2;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RR = 3;
   localparam logic [7:0] FS = 8'd1;
   localparam logic [7:0] CS = 8'd64;

   logic        clk    = 1'b0;
   logic        reset  = 1'b0;
   logic        add_n  = 1'b1;
   logic        sub_n  = 1'b1;
   logic        sel    = 1'b0;
   logic        coarse = 1'b0;
   logic        clear  = 1'b0;
   logic [15:0] phase_out;
   logic        step_pulse;
   logic [1:0]  state_dbg;

   int n_pass  = 0;
   int n_total = 0;

   phase_offset_ctrl #(
      .PHASE_W         (8),
      .CHANNELS        (CH),
      .FINE_STEP       (1),
      .COARSE_STEP     (64),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .add_n      (add_n),
      .sub_n      (sub_n),
      .sel        (sel),
      .coarse     (coarse),
      .clear      (clear),
      .phase_out  (phase_out),
      .step_pulse (step_pulse),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking helper ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Debounce: a button's accepted level flips once the last DB synchronised
   // samples (raw input delayed two edges) all disagree with it.
   // Stepping: first step two edges after a lone press is accepted, then
   // repeats at hold ages RD+1, RD+1+RR, ... until the hold is broken.
   logic [7:0]  m_ph [2];
   int          m_mode;     // 0 waiting, 1 press accepted, 2 holding
   bit          m_dir;
   int          m_ch;
   logic [7:0]  m_step;
   int          m_age;
   int          m_n;
   bit [1:0]    m_deb;
   bit          hist [2][16384];
   logic [16:0] exp_q [$];

   function automatic bit s2(input int b, input int n);
      if (n < 3) return 1'b1;
      return hist[b][n-3];
   endfunction

   always @(posedge clk or negedge reset) begin : model
      bit a_p, s_p, stepped, leave, flip;
      if (!reset) begin
         m_ph[0] = 8'd0;
         m_ph[1] = 8'd0;
         m_mode  = 0;
         m_age   = 0;
         m_n     = 0;
         m_deb   = 2'b11;
         exp_q.delete();
         exp_q.push_back(17'd0);
      end else begin
         m_n++;
         if (m_n <= 16384) begin
            hist[0][m_n-1] = add_n;
            hist[1][m_n-1] = sub_n;
         end
         a_p = !m_deb[0];
         s_p = !m_deb[1];
         stepped = 1'b0;
         if (m_mode == 0) begin
            if (a_p ^ s_p) begin
               m_mode = 1;
               m_dir  = s_p;
               m_ch   = (int'(sel) < CH) ? int'(sel) : 0;
               m_step = coarse ? CS : FS;
            end
         end else if (m_mode == 1) begin
            stepped = 1'b1;
            m_mode  = 2;
            m_age   = 0;
         end else begin
            leave = m_dir ? (!s_p || a_p) : (!a_p || s_p);
            if (leave) m_mode = 0;
            else begin
               m_age++;
               if (m_age >= RD + 1 && ((m_age - RD - 1) % RR) == 0) stepped = 1'b1;
            end
         end
         if (stepped) m_ph[m_ch] = m_dir ? (m_ph[m_ch] - m_step) : (m_ph[m_ch] + m_step);
         if (clear) m_ph[int'(sel)] = 8'd0;
         for (int b = 0; b < 2; b++) begin
            flip = 1'b1;
            for (int j = 0; j < DB; j++) begin
               if (s2(b, m_n - j) == m_deb[b]) flip = 1'b0;
            end
            if (flip) m_deb[b] = !m_deb[b];
         end
         exp_q.push_back({stepped || clear, m_ph[1], m_ph[0]});
      end
   end

   // ---------------- scoreboard compare (every cycle, on the falling edge) ----------------
   always @(negedge clk) begin : compare
      logic [16:0] e;
      if (exp_q.size() == 0) begin
         n_total++;
         $display("FAIL model_queue: got empty, expected one entry at t=%0t", $time);
      end else begin
         e = exp_q.pop_front();
         check("phase_out", 32'(phase_out), 32'(e[15:0]));
         check("step_pulse", 32'(step_pulse), 32'(e[16]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int pulses;
      int ra;
      int rs;

      // reset state
      cyc(2);
      check("reset_phase", 32'(phase_out), 32'd0);
      check("reset_pulse", 32'(step_pulse), 32'd0);
      reset = 1'b1;
      cyc(5);

      // 1: single coarse press on channel 1, update lands on edge 8
      sel = 1'b1; coarse = 1'b1; add_n = 1'b0;
      cyc(6);
      add_n = 1'b1;
      cyc(1);
      check("t1_e7_ch1", 32'(phase_out[15:8]), 32'd0);
      check("t1_e7_pulse", 32'(step_pulse), 32'd0);
      cyc(1);
      check("t1_e8_ch1", 32'(phase_out[15:8]), 32'd64);
      check("t1_e8_ch0", 32'(phase_out[7:0]), 32'd0);
      check("t1_e8_pulse", 32'(step_pulse), 32'd1);
      cyc(1);
      check("t1_e9_pulse", 32'(step_pulse), 32'd0);
      cyc(20);
      check("t1_settled", 32'(phase_out), 32'h4000);

      // 2: bouncing button never qualifies
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         add_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
         cyc(1);
         if (step_pulse) pulses++;
      end
      add_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         if (step_pulse) pulses++;
      end
      check("t2_pulses", 32'(pulses), 32'd0);
      check("t2_phase", 32'(phase_out), 32'h4000);

      // 3: fine decrement wraps, then auto-repeats every RR from 11 after the first step
      sel = 1'b0; coarse = 1'b0; sub_n = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         cyc(1);
         if (i == 8)  check("t3_first", 32'(phase_out[7:0]), 32'd255);
         if (i == 18) check("t3_before_rep", 32'(phase_out[7:0]), 32'd255);
         if (i == 19) check("t3_rep1", 32'(phase_out[7:0]), 32'd254);
         if (i == 22) check("t3_rep2", 32'(phase_out[7:0]), 32'd253);
      end
      sub_n = 1'b1;
      cyc(20);
      check("t3_final", 32'(phase_out), 32'h40F5);

      // 4: both pressed -> nothing; drop add -> one decrement
      add_n = 1'b0; sub_n = 1'b0;
      cyc(15);
      check("t4_both", 32'(phase_out), 32'h40F5);
      add_n = 1'b1;
      cyc(7);
      check("t4_e22", 32'(phase_out[7:0]), 32'd245);
      cyc(1);
      check("t4_e23", 32'(phase_out[7:0]), 32'd244);
      check("t4_e23_pulse", 32'(step_pulse), 32'd1);
      cyc(1);
      sub_n = 1'b1;
      cyc(20);
      check("t4_final", 32'(phase_out), 32'h40F4);

      // 5: clear wins over a same-cycle step to the same channel
      sel = 1'b0; coarse = 1'b1; add_n = 1'b0;
      cyc(7);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0; add_n = 1'b1;
      check("t5_ch0", 32'(phase_out[7:0]), 32'd0);
      check("t5_ch1", 32'(phase_out[15:8]), 32'd64);
      check("t5_pulse", 32'(step_pulse), 32'd1);
      cyc(20);
      check("t5_final", 32'(phase_out), 32'h4000);

      // 6: reset while repeating, button still held
      sel = 1'b1; coarse = 1'b0; add_n = 1'b0;
      cyc(23);
      check("t6_before", 32'(phase_out[15:8]), 32'h43);
      reset = 1'b0;
      #1;
      check("t6_reset_now", 32'(phase_out), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      cyc(7);
      check("t6_r7", 32'(phase_out), 32'd0);
      cyc(1);
      check("t6_r8", 32'(phase_out), 32'h0100);
      check("t6_r8_pulse", 32'(step_pulse), 32'd1);
      add_n = 1'b1;
      cyc(20);

      // random phase, checked against the model every cycle
      ra = 0; rs = 0;
      for (int i = 0; i < 3000; i++) begin
         if (ra == 0) begin
            add_n = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 40));
         end
         ra--;
         if (rs == 0) begin
            sub_n = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 40));
         end
         rs--;
         if ($urandom_range(0, 7) == 0) sel = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) coarse = 1'($urandom_range(0, 1));
         clear = ($urandom_range(0, 15) == 0);
         reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
         cyc(1);
      end
      clear = 1'b0; add_n = 1'b1; sub_n = 1'b1; reset = 1'b1;
      cyc(12);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
